// File: rtl/speed_select_pkg.sv
// Shared constants for the speed selector: DIV codes understood by the clock divider
// and the top of the speed index range.
package speed_select_pkg;

  localparam logic [2:0] DIV_HALF_HZ    = 3'b000;
  localparam logic [2:0] DIV_ONE_HZ     = 3'b001;
  localparam logic [2:0] DIV_ONEHALF_HZ = 3'b010;
  localparam logic [2:0] DIV_TWO_HZ     = 3'b011;
  localparam logic [2:0] DIV_DEBOUNCE   = 3'b100;

  localparam logic [1:0] SPEED_MAX = 2'd3;

  // This stage only ever selects one of the four output rates.
  function automatic logic [2:0] idx_to_div(input logic [1:0] idx);
    return {1'b0, idx};
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One push-button: 2-flop synchronizer, consecutive-cycle debounce counter and a
// registered one-cycle press pulse on each debounced rising level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic clean,
  output logic press
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             clean_d;
  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1   <= 1'b0;
      sync2   <= 1'b0;
      clean   <= 1'b0;
      clean_d <= 1'b0;
      press   <= 1'b0;
      cnt     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge value of its source.
      sync1   <= btn;
      sync2   <= sync1;
      clean_d <= clean;
      press   <= clean & ~clean_d;
      if (sync2 != clean) begin
        if (cnt == CNT_LAST) begin
          clean <= sync2;
          cnt   <= '0;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else begin
        cnt <= '0;  // any bounce back to the stable level restarts the count
      end
    end
  end

endmodule

// File: rtl/speed_select.sv
// Debounced faster/slower buttons step a speed index that drives the divider's DIV select.
// Define SPEED_WRAP_EN to wrap 3->0 / 0->3 instead of saturating.
module speed_select
  import speed_select_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = 20,
  parameter int RESET_IDX       = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_up,
  input  logic       btn_down,
  output logic [2:0] div,
  output logic [1:0] speed_idx,
  output logic       changed,
  output logic       up_clean,
  output logic       down_clean
);

  logic       up_press;
  logic       down_press;
  logic [1:0] idx_q;
  logic [1:0] idx_nxt;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_up (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_up),
    .clean (up_clean),
    .press (up_press)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_down (
    .clk   (clk),
    .rst   (rst),
    .btn   (btn_down),
    .clean (down_clean),
    .press (down_press)
  );

  always_comb begin
    // NOTE: default first so every path assigns idx_nxt and no latch is inferred.
    idx_nxt = idx_q;
    if (up_press && !down_press) begin
`ifdef SPEED_WRAP_EN
      idx_nxt = idx_q + 2'd1;
`else
      if (idx_q != SPEED_MAX) idx_nxt = idx_q + 2'd1;
`endif
    end else if (down_press && !up_press) begin
`ifdef SPEED_WRAP_EN
      idx_nxt = idx_q - 2'd1;
`else
      if (idx_q != 2'd0) idx_nxt = idx_q - 2'd1;
`endif
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q   <= 2'(RESET_IDX);
      changed <= 1'b0;
    end else begin
      idx_q   <= idx_nxt;
      changed <= (idx_nxt != idx_q);  // a press at saturation is not a change
    end
  end

  assign speed_idx = idx_q;
  assign div       = idx_to_div(idx_q);

endmodule

// File: tb/tb_speed_select.sv
// Self-checking bench for speed_select: directed scenarios plus random button traffic,
// every cycle compared against a window-based behavioural model.
module tb_speed_select;

  localparam int N  = 4;
  localparam int RI = 1;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       btn_up = 1'b0;
  logic       btn_down = 1'b0;
  logic [2:0] div;
  logic [1:0] speed_idx;
  logic       changed;
  logic       up_clean;
  logic       down_clean;

  int errors = 0;
  int checks = 0;

  speed_select #(.DEBOUNCE_CYCLES(N), .CNT_W(8), .RESET_IDX(RI)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_up     (btn_up),
    .btn_down   (btn_down),
    .div        (div),
    .speed_idx  (speed_idx),
    .changed    (changed),
    .up_clean   (up_clean),
    .down_clean (down_clean)
  );

  always #5 clk = ~clk;

  // Model: h_*[0] is the newest raw sample. The clean level flips when the N samples
  // taken 2..N+1 edges ago all differ from it; press follows one edge after a rise.
  bit h_up[0:N];
  bit h_dn[0:N];
  bit m_uc, m_dc, m_uc_d, m_dc_d, m_pu, m_pd, m_chg;
  int m_idx;

  task automatic model_reset();
    for (int i = 0; i <= N; i++) begin
      h_up[i] = 1'b0;
      h_dn[i] = 1'b0;
    end
    {m_uc, m_dc, m_uc_d, m_dc_d, m_pu, m_pd, m_chg} = '0;
    m_idx = RI;
  endtask

  function automatic bit window_differs(input bit h[0:N], input bit lvl);
    for (int i = 1; i <= N; i++)
      if (h[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_edge(input bit u, input bit d);
    int  tgt;
    bit  n_uc, n_dc;
    tgt = m_idx;
    if (m_pu != m_pd) begin
      tgt = m_pu ? m_idx + 1 : m_idx - 1;
`ifdef SPEED_WRAP_EN
      tgt = (tgt + 4) % 4;
`else
      if (tgt > 3) tgt = 3;
      if (tgt < 0) tgt = 0;
`endif
    end
    m_chg = (tgt != m_idx);
    m_idx = tgt;
    m_pu  = m_uc & ~m_uc_d;
    m_pd  = m_dc & ~m_dc_d;
    n_uc  = window_differs(h_up, m_uc) ? ~m_uc : m_uc;
    n_dc  = window_differs(h_dn, m_dc) ? ~m_dc : m_dc;
    m_uc_d = m_uc;
    m_dc_d = m_dc;
    m_uc  = n_uc;
    m_dc  = n_dc;
    for (int i = N; i > 0; i--) begin
      h_up[i] = h_up[i-1];
      h_dn[i] = h_dn[i-1];
    end
    h_up[0] = u;
    h_dn[0] = d;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ":div"},        8'(div),        8'(m_idx));
    check({tag, ":speed_idx"},  8'(speed_idx),  8'(m_idx));
    check({tag, ":changed"},    8'(changed),    8'(m_chg));
    check({tag, ":up_clean"},   8'(up_clean),   8'(m_uc));
    check({tag, ":down_clean"}, 8'(down_clean), 8'(m_dc));
  endtask

  // One clock: drive on the falling edge, advance the model on the rising edge, check 1 time unit later.
  task automatic cycle(input bit u, input bit d, input bit r, input string tag);
    @(negedge clk);
    btn_up   = u;
    btn_down = d;
    rst      = r;
    @(posedge clk);
    if (r) model_reset();
    else   model_edge(u, d);
    #1;
    check_all(tag);
  endtask

  task automatic do_reset();
    cycle(1'b0, 1'b0, 1'b1, "rst");
    cycle(1'b0, 1'b0, 1'b1, "rst");
  endtask

  initial begin
    int exp_idx[4];
    int seg, u, d;
    model_reset();

    // 1: reset state
    do_reset();
    check("t1_div", 8'(div), 8'h01);
    check("t1_changed", 8'(changed), 8'h00);
    check("t1_cleans", 8'({up_clean, down_clean}), 8'h00);

    // 2: held up button, exact latency, single step
    for (int e = 0; e <= 8; e++) begin
      cycle(1'b1, 1'b0, 1'b0, "t2");
      if (e == 4) check("t2_up_clean_e4", 8'(up_clean), 8'h00);
      if (e == 5) check("t2_up_clean_e5", 8'(up_clean), 8'h01);
      if (e == 6) check("t2_div_e6", 8'(div), 8'h01);
      if (e == 7) check("t2_div_chg_e7", 8'({div, changed}), 8'({3'b010, 1'b1}));
      if (e == 8) check("t2_changed_e8", 8'(changed), 8'h00);
    end
    for (int e = 0; e < 50; e++) cycle(1'b1, 1'b0, 1'b0, "t2_hold");
    check("t2_div_after_hold", 8'(div), 8'h02);
    for (int e = 0; e < 10; e++) cycle(1'b0, 1'b0, 1'b0, "t2_rel");

    // 3: bouncing down button never qualifies
    for (int e = 0; e < 20; e++) begin
      cycle(1'((e / 2) % 2), 1'b0, 1'b0, "t3_dummy");
    end
    for (int e = 0; e < 20; e++) begin
      cycle(1'b0, 1'((e / 2) % 2 == 0), 1'b0, "t3");
      check("t3_down_clean", 8'(down_clean), 8'h00);
      check("t3_changed", 8'(changed), 8'h00);
    end
    for (int e = 0; e < 8; e++) cycle(1'b0, 1'b0, 1'b0, "t3_low");
    check("t3_div", 8'(div), 8'h02);

    // 4: four separate presses from index 1
`ifdef SPEED_WRAP_EN
    exp_idx = '{2, 3, 0, 1};
`else
    exp_idx = '{2, 3, 3, 3};
`endif
    do_reset();
    for (int p = 0; p < 4; p++) begin
      for (int e = 0; e < 8; e++) cycle(1'b1, 1'b0, 1'b0, "t4_press");
      check("t4_idx", 8'(speed_idx), 8'(exp_idx[p]));
      for (int e = 0; e < 8; e++) cycle(1'b0, 1'b0, 1'b0, "t4_rel");
    end

    // 5: both buttons together
    do_reset();
    for (int e = 0; e <= 11; e++) begin
      cycle(1'b1, 1'b1, 1'b0, "t5");
      if (e == 4) check("t5_cleans_e4", 8'({up_clean, down_clean}), 8'h00);
      if (e == 5) check("t5_cleans_e5", 8'({up_clean, down_clean}), 8'h03);
      if (e == 7) check("t5_div_chg_e7", 8'({div, changed}), 8'({3'b001, 1'b0}));
    end
    for (int e = 0; e < 8; e++) cycle(1'b0, 1'b0, 1'b0, "t5_rel");

    // 6: reset mid-debounce with button held
    do_reset();
    for (int e = 0; e <= 3; e++) cycle(1'b1, 1'b0, 1'b0, "t6_pre");
    rst = 1'b1;
    #1;
    model_reset();
    check("t6_async_div", 8'(div), 8'h01);
    check_all("t6_async");
    cycle(1'b1, 1'b0, 1'b1, "t6_rst");
    cycle(1'b1, 1'b0, 1'b1, "t6_rst");
    for (int e = 0; e <= 8; e++) begin
      cycle(1'b1, 1'b0, 1'b0, "t6_post");
      if (e == 6) check("t6_div_e6", 8'(div), 8'h01);
      if (e == 7) check("t6_div_chg_e7", 8'({div, changed}), 8'({3'b010, 1'b1}));
    end
    for (int e = 0; e < 8; e++) cycle(1'b0, 1'b0, 1'b0, "t6_rel");

    // Random traffic: bursts of random length mixing bounces, presses and occasional resets
    for (int s = 0; s < 300; s++) begin
      seg = $urandom_range(1, 10);
      u   = $urandom_range(0, 1);
      d   = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 1) : 0;
      if ($urandom_range(0, 39) == 0) begin
        cycle(1'(u), 1'(d), 1'b1, "rnd_rst");
      end else begin
        for (int e = 0; e < seg; e++) cycle(1'(u), 1'(d), 1'b0, "rnd");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
